// File: rtl/chip8_pkg.sv
// chip8_pkg: shared CHIP-8 constants.
//   - transfer mode encodings for mem_xfer
//   - memory-map constants (register file, framebuffer)
//   - mem_xfer state encoding
package chip8_pkg;

  localparam logic [1:0] XFER_COPY     = 2'd0;
  localparam logic [1:0] XFER_FILL     = 2'd1;
  localparam logic [1:0] XFER_COPY_REV = 2'd2;
  localparam logic [1:0] XFER_RSVD     = 2'd3;

  localparam logic [11:0] REG_BASE    = 12'h020;
  localparam logic [11:0] SCREEN_BASE = 12'h100;
  localparam logic [7:0]  SCREEN_LEN  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_FILL,
    ST_DONE
  } xfer_state_e;

endpackage

// File: rtl/mem_xfer.sv
// mem_xfer: block-transfer engine for the CHIP-8 memory port.
// Runs CLS fill, register copies and framebuffer scroll moves on behalf of
// the CPU, which muxes this block onto the memory bus while busy is high.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start, mode            launch (sampled in IDLE only), transfer kind
//   src, dst, len          base addresses and byte count minus one
//   fill_byte              FILL value
//   abort                  cancel the transfer in progress
//   busy, done             status: busy while active, done one-cycle pulse
//   mem_read, mem_read_idx, mem_read_byte, mem_read_ack    read channel
//   mem_write, mem_write_idx, mem_write_byte               write channel
module mem_xfer
  import chip8_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 8,
  parameter int DATA_W = 8
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_byte,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_read_idx,
  input  logic [DATA_W-1:0] mem_read_byte,
  input  logic              mem_read_ack,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_write_idx,
  output logic [DATA_W-1:0] mem_write_byte
);

  // comparison width wide enough for both an address delta and a length
  localparam int CW = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;

  xfer_state_e       state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  off_q, off_d;
  logic              desc_q, desc_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // A forward copy clobbers unread source bytes when dst lies in
  // (src, src+len] modulo memory size; the distance dst-src tells us.
  logic [ADDR_W-1:0] delta;
  logic              copy_desc;
  logic              start_desc;
  logic [LEN_W-1:0]  off_step;

  assign delta      = dst - src;
  assign copy_desc  = (delta != '0) && (CW'(delta) <= CW'(len));
  assign start_desc = (mode == XFER_COPY_REV) || ((mode == XFER_COPY) && copy_desc);
  assign off_step   = desc_q ? (off_q - LEN_W'(1)) : (off_q + LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      off_q   <= '0;
      desc_q  <= 1'b0;
      fill_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      desc_q  <= desc_d;
      fill_q  <= fill_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    dst_d          = dst_q;
    cnt_d          = cnt_q;
    off_d          = off_q;
    desc_d         = desc_q;
    fill_d         = fill_q;
    rdata_d        = rdata_q;
    done           = 1'b0;
    mem_read       = 1'b0;
    mem_read_idx   = '0;
    mem_write      = 1'b0;
    mem_write_idx  = '0;
    mem_write_byte = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d  = src;
          dst_d  = dst;
          cnt_d  = len;
          fill_d = fill_byte;
          desc_d = start_desc;
          off_d  = start_desc ? len : '0;
          unique case (mode)
            XFER_COPY, XFER_COPY_REV: state_d = ST_READ;
            XFER_FILL:                state_d = ST_FILL;
            default:                  state_d = ST_DONE;
          endcase
        end
      end

      ST_READ: begin
        mem_read_idx = src_q + ADDR_W'(off_q);
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          // hold the request until the ack cycle, then drop it
          mem_read = !mem_read_ack;
          if (mem_read_ack) begin
            rdata_d = mem_read_byte;
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE, ST_FILL: begin
        mem_write_idx  = dst_q + ADDR_W'(off_q);
        mem_write_byte = (state_q == ST_FILL) ? fill_q : rdata_q;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          mem_write = 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q - LEN_W'(1);
            off_d   = off_step;
            state_d = (state_q == ST_FILL) ? ST_FILL : ST_READ;
          end
        end
      end

      ST_DONE: begin
        done    = !abort;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

endmodule
